// File: rtl/addsub_pkg.sv
// Shared definitions for the add/subtract engines: FSM encodings and default width.
package addsub_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : addsub_pkg

// File: rtl/serial_addsub_if.sv
// Request/result bundle for serial_addsub.
//
// Handshake: start is sampled only while the engine is not busy (IDLE or DONE);
// the sampling edge captures a, b, cin and sub. busy is high for the WIDTH
// cycles of the run. done is a one-cycle pulse marking sum/cout as fresh; sum
// and cout then hold until the next completion. start while busy is dropped.
interface serial_addsub_if
    import addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    state_t           state;   // FSM state, exported for observation

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout, state
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout, state
    );

endinterface : serial_addsub_if

// File: rtl/serial_addsub_fa_bit.sv
// Combinational 1-bit full adder used as the single arithmetic cell of the serial engine.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule : fa_bit

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: one full-adder step per clock, LSB first.
// Subtraction is folded into the capture as a + ~b + ~cin, so the run itself
// is always a plain ripple addition.
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    serial_addsub_if.slave bus
);

    localparam int            CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic             accept;
    logic             last_step;
    logic             fa_s;
    logic             fa_co;

    // A request is taken in IDLE and also in DONE so operations can run back-to-back.
    assign accept    = bus.start && ((state_q == IDLE) || (state_q == DONE));
    assign last_step = (state_q == RUN) && (cnt_q == LAST_STEP);

    fa_bit u_fa (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: WIDTH steps in RUN, then a single DONE cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last_step) state_d = DONE;
            DONE:    state_d = accept ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-state: capture on accept, shift/add during RUN, publish on the last step.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        if (accept) begin
            a_d     = bus.a;
            b_d     = bus.b ^ {WIDTH{bus.sub}};
            carry_d = bus.cin ^ bus.sub;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            r_d     = {fa_s, r_q[WIDTH-1:1]};
            carry_d = fa_co;
            cnt_d   = cnt_q + 1'b1;
            // The final sum bit is produced on this same edge, so publish the
            // shift register contents including it.
            if (last_step) begin
                sum_d  = {fa_s, r_q[WIDTH-1:1]};
                cout_d = fa_co;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.busy  = (state_q == RUN);
    assign bus.done  = (state_q == DONE);
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
    assign bus.state = state_q;

endmodule : serial_addsub

// File: doc/serial_addsub.md
# serial_addsub

Bit-serial, multi-cycle add/subtract engine with the same arithmetic contract as the combinational `addsub` (`a`, `b`, `cin`, `sub` in; `sum`, `cout` out). It processes one bit per clock, LSB first, behind a start/done handshake. It is the area-minimal sequential counterpart for datapaths that can tolerate WIDTH cycles of latency. Results are bit-exact with `addsub` for every operand combination.

## Interface
- `WIDTH`, default 4: operand and result width in bits; must be ≥ 2.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request; sampled only when the block is not busy.
- `a`  in  WIDTH: first operand, captured on the accepted `start`.
- `b`  in  WIDTH: second operand, captured on the accepted `start`.
- `cin`  in  1: carry-in (add) or borrow-in (sub), captured on the accepted `start`.
- `sub`  in  1: 0 = add, 1 = subtract, captured on the accepted `start`.
- `busy`  out  1: high while an operation is in progress.
- `done`  out  1: single-cycle pulse; `sum`/`cout` are valid.
- `sum`  out  WIDTH: result, held until the next completion.
- `cout`  out  1: carry-out (add) or no-borrow flag (sub).

## Operation
- **Add:** {cout,sum} = a + b + cin.
- **Subtract:** sum = (a − b − cin) mod 2^WIDTH.
  - Computed as a + ~b + ~cin.
  - cout = 1 iff a ≥ b + cin (no borrow).
- **FSM states:** IDLE, RUN, DONE.
  - IDLE, `start`=1: latch a, b^{WIDTH{sub}}, carry = cin^sub; clear bit counter; go to RUN.
  - RUN: each cycle, one full-adder step on operand bit 0 and the carry. The sum bit shifts into the MSB of an internal result shift register, both operand registers shift right, and carry updates. After WIDTH steps go to DONE.
  - DONE: `done`=1. `start`=1 here is accepted exactly as in IDLE (back-to-back); otherwise go to IDLE.
- `start` during RUN is ignored and not queued.
- `sum`/`cout` outputs load from the internal shift register and carry only on the RUN→DONE edge. They hold their value through later runs until the next completion.
- Input ports may change freely after the capture edge without affecting the result.
- **Reset** (any time, including mid-RUN):
  - State goes to IDLE.
  - `busy`, `done`, `sum`, `cout`, counter, carry and shift registers go to 0.
  - The in-flight operation is discarded; no `done` is issued for it.

## Timing
- Edge E0 samples `start`=1 (IDLE or DONE). `busy`=1 from after E0 through E_WIDTH.
- Bit i is computed on edge E(i+1), for i = 0..WIDTH−1.
- Edge E_WIDTH moves to DONE.
  - `done`=1 and new `sum`/`cout` are visible in the cycle after E_WIDTH.
  - Latency from `start` to `done` is WIDTH cycles.
- Throughput: one operation per WIDTH+1 cycles when `start` is held high or reasserted in DONE.
- `busy` and `done` are never high together. `busy` drops at the E_WIDTH edge.
- Counter width is $clog2(WIDTH+1); the counter does not wrap during an operation.
- Asynchronous reset takes effect immediately; outputs read 0 before the next clock edge.

## Structure
- Shared package `addsub_pkg`:
  - FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Default WIDTH constant, also used by `addsub`.
- One sub-module, `fa_bit`: a combinational 1-bit full adder (a, b, ci → s, co), instantiated once.
- FSM, counter, and shift registers live in `serial_addsub`.

## Test plan
Each bench check compares against `addsub` instantiated with the same inputs.
- Add, a=10, b=6, cin=1, sub=0 → `done` exactly 4 cycles after `start`; sum=4'b0001, cout=1.
- Add, a=4, b=5, cin=1 → sum=4'b1010, cout=0. Then immediately sub, a=4, b=5, cin=0, with `start` held in DONE → sum=4'b1111, cout=0; no idle cycle between operations.
- Sub, a=12, b=3, cin=1 → sum=4'b1000, cout=1. Operand inputs are changed to 15/10 in the cycle after capture; the result must be unaffected.
- Sub, a=15, b=10, cin=1 → sum=4'b0100, cout=1. A second `start` pulse at cycle 2 of RUN is ignored: exactly one `done`, and `busy` stays high 4 cycles.
- Assert `rst` for one cycle at cycle 2 of a run (a=7, b=9, add):
  - All outputs read 0 immediately.
  - No `done` follows.
  - A fresh add, a=1, b=1, cin=0 → sum=4'b0010, cout=0.
- Exhaustive sweep, WIDTH=4: all a, b, cin, sub; every result matches `addsub`. Rerun with WIDTH=8 using random vectors.
